// File: rtl/muldiv_seq.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One shared 32-bit add/subtract step per cycle, 32 iterations plus a sign fix-up cycle.
module muldiv_seq (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        whi,
    input  logic        wlo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    function automatic logic [31:0] neg32(input logic signed [31:0] x);
        return 32'(-x);
    endfunction

    function automatic logic [63:0] neg64(input logic signed [63:0] x);
        return 64'(-x);
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? neg32(x) : x;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d, done_q, done_d;

    // acc_q doubles as the remainder and mplr_q as the quotient when dividing
    logic [31:0] acc_q, acc_d, mplr_q, mplr_d, opnd_q, opnd_d, araw_q, araw_d;
    logic        is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;

    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_trial;
    logic        div_neg;
    logic [63:0] prod, prod_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {acc_q, mplr_q[31]};
        div_trial = div_shift - {1'b0, opnd_q};
        // a shifted remainder at or above 2^32 always exceeds any 32-bit divisor
        div_neg   = ~div_shift[32] & div_trial[32];
        prod      = {acc_q, mplr_q};
        prod_fix  = neg_res_q ? neg64(prod) : prod;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        opnd_d    = opnd_q;
        araw_d    = araw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (whi) hi_d = wdata;
                if (wlo) lo_d = wdata;
                if (start && !flush) begin
                    state_d   = S_CALC;
                    busy_d    = 1'b1;
                    cnt_d     = 5'd0;
                    is_div_d  = op[1];
                    neg_res_d = op[0] & (a[31] ^ b[31]);
                    neg_rem_d = op[0] & a[31];
                    dz_d      = (b == 32'd0);
                    araw_d    = a;
                    acc_d     = 32'd0;
                    if (op[1]) begin
                        mplr_d = mag32(a, op[0]);
                        opnd_d = mag32(b, op[0]);
                    end else begin
                        mplr_d = mag32(b, op[0]);
                        opnd_d = mag32(a, op[0]);
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div_q) begin
                        acc_d  = div_neg ? div_shift[31:0] : div_trial[31:0];
                        mplr_d = {mplr_q[30:0], ~div_neg};
                    end else begin
                        acc_d  = mul_sum[32:1];
                        mplr_d = {mul_sum[0], mplr_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (dz_q) begin
                        hi_d = araw_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = neg_rem_q ? neg32(acc_q) : acc_q;
                        lo_d = neg_res_q ? neg32(mplr_q) : mplr_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // datapath registers are always loaded at start before they are used
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        mplr_q    <= mplr_d;
        opnd_q    <= opnd_d;
        araw_q    <= araw_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        dz_q      <= dz_d;
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table of mul/div results plus
// hand-written sequences for writes, flush, reset and back-to-back issue.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        clrn, start, whi, wlo, flush;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
        .whi(whi), .wlo(wlo), .wdata(wdata), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Called at the negedge where start was raised; returns at the negedge of the done cycle.
    task automatic wait_done(input string nm, input logic [31:0] eh, input logic [31:0] el, input int inj);
        int cyc;
        int nb;
        cyc = 0;
        nb  = 0;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) nb++;
            start = (cyc == inj);
            wlo   = (cyc == inj);
            if (cyc == inj) begin
                op    = 2'b10;
                a     = 32'd100;
                b     = 32'd7;
                wdata = 32'hDEAD;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        wlo   = 1'b0;
        if (done !== 1'b1) begin
            check({nm, " timeout"}, 64'(cyc), 64'd33);
        end else begin
            check({nm, " latency"}, 64'(cyc), 64'd33);
            check({nm, " busy cycles"}, 64'(nb), 64'd33);
            check({nm, " busy low at done"}, 64'(busy), 64'd0);
            check({nm, " hi"}, 64'(hi), 64'(eh));
            check({nm, " lo"}, 64'(lo), 64'(el));
        end
    endtask

    task automatic quiet(input string nm, input int n);
        int nd;
        int nbz;
        nd  = 0;
        nbz = 0;
        repeat (n) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (busy === 1'b1) nbz++;
        end
        check({nm, " extra done"}, 64'(nd), 64'd0);
        check({nm, " extra busy"}, 64'(nbz), 64'd0);
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'b01, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5] = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[6] = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{2'b10, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};

        clrn = 1'b0; start = 1'b0; whi = 1'b0; wlo = 1'b0; flush = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        clrn = 1'b1;
        @(negedge clk);

        wlo = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        wlo = 1'b0;
        check("mtlo lo", 64'(lo), 64'h1234);
        check("mtlo hi untouched", 64'(hi), 64'd0);
        whi = 1'b1; wlo = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        whi = 1'b0; wlo = 1'b0;
        check("mthi+mtlo hi", 64'(hi), 64'h5678);
        check("mthi+mtlo lo", 64'(lo), 64'h5678);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, -1);
            @(negedge clk);
            check($sformatf("vec%0d done single", i), 64'(done), 64'd0);
        end

        // wlo and a second start while busy must both be ignored
        issue(2'b00, 32'd3, 32'd4);
        wait_done("busy-ignore", 32'd0, 32'd12, 10);
        quiet("busy-ignore", 40);

        // flush in IDLE drops start but keeps the MTHI write
        flush = 1'b1; whi = 1'b1; wdata = 32'h77;
        issue(2'b00, 32'd3, 32'd4);
        @(negedge clk);
        flush = 1'b0; whi = 1'b0; start = 1'b0;
        check("idle flush busy", 64'(busy), 64'd0);
        check("idle flush whi", 64'(hi), 64'h77);
        quiet("idle flush", 36);

        // flush mid-divide
        whi = 1'b1; wdata = 32'hAAAA;
        @(negedge clk);
        whi = 1'b0; wlo = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        wlo = 1'b0;
        issue(2'b10, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy drop", 64'(busy), 64'd0);
        quiet("flush", 40);
        check("flush hi kept", 64'(hi), 64'hAAAA);
        check("flush lo kept", 64'(lo), 64'h5555);

        // reset mid-divide
        issue(2'b10, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        quiet("midreset", 40);

        // second op issued in the done cycle of the first
        issue(2'b00, 32'd5, 32'd5);
        wait_done("b2b first", 32'd0, 32'd25, -1);
        issue(2'b00, 32'd2, 32'd3);
        wait_done("b2b second", 32'd0, 32'd6, -1);
        @(negedge clk);
        check("b2b done single", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
